// File: rtl/barrier_sync_ctrl.sv
// Purpose: kernel-level SYNC/EXIT sequencer; launches a kernel, gathers cores at barriers, flags completion.
// Latency: barrier_release one cycle after the last arrival is sampled; kernel_done one cycle after the last exit.
// Backpressure: none; cores hold sync_req until released; start is ignored while busy.
module barrier_sync_ctrl #(
   parameter int NUM_CORES     = 4,
   parameter int TIMEOUT_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [NUM_CORES-1:0] core_mask,
   input  logic [NUM_CORES-1:0] sync_req,
   input  logic [NUM_CORES-1:0] exit_req,
   output logic [NUM_CORES-1:0] core_active,
   output logic [NUM_CORES-1:0] barrier_release,
   output logic [7:0]           barrier_count,
   output logic                 busy,
   output logic                 kernel_done,
   output logic                 timeout_err
);

   typedef enum logic [1:0] {IDLE, RUN, RELEASE, DONE} state_t;

   localparam logic [TIMEOUT_WIDTH-1:0] WAIT_MAX  = '1;
   localparam logic [TIMEOUT_WIDTH-1:0] WAIT_LAST = WAIT_MAX - TIMEOUT_WIDTH'(1);

   state_t                   state_q;
   logic [NUM_CORES-1:0]     active_q;
   logic [NUM_CORES-1:0]     arrived_q;
   logic [NUM_CORES-1:0]     release_q;
   logic [TIMEOUT_WIDTH-1:0] wait_cnt_q;
   logic [7:0]               count_q;
   logic                     busy_q;
   logic                     done_q;
   logic                     timeout_q;

   logic [NUM_CORES-1:0]     exits_d;
   logic [NUM_CORES-1:0]     act_d;
   logic [NUM_CORES-1:0]     arr_d;

   // Next active/arrived sets; an exit on a core overrides its SYNC in the same cycle.
   always_comb begin
      exits_d = exit_req & active_q;
      act_d   = active_q & ~exits_d;
      arr_d   = (arrived_q | (sync_req & active_q)) & ~exits_d;
   end

   // Sequencer FSM with all outputs held in registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         active_q   <= '0;
         arrived_q  <= '0;
         release_q  <= '0;
         wait_cnt_q <= '0;
         count_q    <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         release_q <= '0;
         done_q    <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  active_q   <= core_mask;
                  arrived_q  <= '0;
                  count_q    <= '0;
                  wait_cnt_q <= '0;
                  timeout_q  <= 1'b0;
                  busy_q     <= 1'b1;
                  if (core_mask == '0) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                  end else begin
                     state_q <= RUN;
                  end
               end
            end
            RUN: begin
               active_q  <= act_d;
               arrived_q <= arr_d;
               // Watchdog only runs while someone is parked at the barrier; it never releases.
               if (arrived_q != '0 && wait_cnt_q != WAIT_MAX) begin
                  wait_cnt_q <= wait_cnt_q + TIMEOUT_WIDTH'(1);
                  if (wait_cnt_q == WAIT_LAST) begin
                     timeout_q <= 1'b1;
                  end
               end
               if (act_d == '0) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else if (arr_d == act_d) begin
                  state_q   <= RELEASE;
                  release_q <= arr_d;
               end
            end
            RELEASE: begin
               active_q   <= act_d;
               arrived_q  <= '0;
               wait_cnt_q <= '0;
               count_q    <= count_q + 8'd1;
               if (act_d == '0) begin
                  state_q <= DONE;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= RUN;
               end
            end
            DONE: begin
               active_q  <= '0;
               arrived_q <= '0;
               busy_q    <= 1'b0;
               state_q   <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign core_active     = active_q;
   assign barrier_release = release_q;
   assign barrier_count   = count_q;
   assign busy            = busy_q;
   assign kernel_done     = done_q;
   assign timeout_err     = timeout_q;

endmodule

// File: tb/tb_barrier_sync_ctrl.sv
// Purpose: directed stimulus for barrier_sync_ctrl with a cycle-level reference model and literal spot checks.
// Latency: model predicts the registered outputs visible after each rising edge.
// Backpressure: not applicable; inputs are driven 1 time unit after each rising edge.
module tb_barrier_sync_ctrl;

   localparam int N    = 4;
   localparam int TW   = 4;
   localparam int WMAX = (1 << TW) - 1;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic [N-1:0] core_mask = '0;
   logic [N-1:0] sync_req = '0;
   logic [N-1:0] exit_req = '0;
   logic [N-1:0] core_active;
   logic [N-1:0] barrier_release;
   logic [7:0]   barrier_count;
   logic         busy;
   logic         kernel_done;
   logic         timeout_err;

   int n_chk  = 0;
   int n_fail = 0;
   bit chk_en = 1'b0;

   barrier_sync_ctrl #(.NUM_CORES(N), .TIMEOUT_WIDTH(TW)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .core_mask(core_mask),
      .sync_req(sync_req), .exit_req(exit_req), .core_active(core_active),
      .barrier_release(barrier_release), .barrier_count(barrier_count),
      .busy(busy), .kernel_done(kernel_done), .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: phase is implied by the outputs (done pulse, pending release, busy).
   logic [N-1:0] m_act = '0, m_arr = '0, m_rel = '0;
   int           m_cnt = 0, m_wait = 0;
   bit           m_busy = 0, m_done = 0, m_to = 0;

   always @(posedge clk or negedge rst_n) begin
      logic [N-1:0] ex, na, nr;
      if (!rst_n) begin
         m_act = '0; m_arr = '0; m_rel = '0; m_cnt = 0; m_wait = 0;
         m_busy = 0; m_done = 0; m_to = 0;
      end else if (m_done) begin
         m_done = 0; m_busy = 0; m_act = '0; m_arr = '0;
      end else if (m_rel != '0) begin
         m_act  = m_act & ~exit_req;
         m_rel  = '0; m_arr = '0; m_wait = 0;
         m_cnt  = (m_cnt + 1) % 256;
         if (m_act == '0) m_done = 1;
      end else if (m_busy) begin
         if (m_arr != '0) begin
            if (m_wait < WMAX) m_wait++;
            if (m_wait == WMAX) m_to = 1;
         end
         ex = exit_req & m_act;
         na = m_act & ~ex;
         nr = (m_arr | (sync_req & m_act)) & ~ex;
         m_act = na;
         m_arr = nr;
         if (na == '0) m_done = 1;
         else if (nr == na) m_rel = nr;
      end else if (start) begin
         m_act = core_mask; m_arr = '0; m_cnt = 0; m_wait = 0; m_to = 0; m_busy = 1;
         if (core_mask == '0) m_done = 1;
      end
   end

   // Every-cycle comparison of all outputs against the model, away from the rising edge.
   always @(negedge clk) begin
      if (chk_en) begin
         chk("m_core_active", 32'(core_active), 32'(m_act));
         chk("m_release", 32'(barrier_release), 32'(m_rel));
         chk("m_count", 32'(barrier_count), 32'(m_cnt));
         chk("m_busy", 32'(busy), 32'(m_busy));
         chk("m_done", 32'(kernel_done), 32'(m_done));
         chk("m_timeout", 32'(timeout_err), 32'(m_to));
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [N-1:0] m);
      start = 1'b1; core_mask = m;
      cyc(1);
      start = 1'b0; core_mask = '0;
   endtask

   initial begin
      cyc(2);
      rst_n = 1'b1;
      chk_en = 1'b1;
      chk("reset_active", 32'(core_active), 0);
      chk("reset_busy", 32'(busy), 0);
      chk("reset_count", 32'(barrier_count), 0);

      // All four cores, staggered arrivals; release follows the last one.
      launch(4'b1111);
      chk("t1_busy", 32'(busy), 1);
      chk("t1_active", 32'(core_active), 32'h0f);
      cyc(1); sync_req = 4'b0001;
      cyc(3); sync_req = 4'b0111;
      cyc(4);
      chk("t1_no_early_release", 32'(barrier_release), 0);
      sync_req = 4'b1111;
      cyc(1);
      chk("t1_release", 32'(barrier_release), 32'h0f);
      cyc(1);
      chk("t1_release_pulse", 32'(barrier_release), 0);
      chk("t1_count", 32'(barrier_count), 1);
      sync_req = '0;
      exit_req = 4'b1111; cyc(1); exit_req = '0;
      chk("t1_done", 32'(kernel_done), 1);
      cyc(1);
      chk("t1_idle_busy", 32'(busy), 0);

      // Sparse mask; SYNC from inactive cores must not count.
      launch(4'b0101);
      sync_req = 4'b1010;
      cyc(5);
      chk("t2_no_release", 32'(barrier_release), 0);
      chk("t2_no_timeout", 32'(timeout_err), 0);
      sync_req = 4'b1111;
      cyc(1);
      chk("t2_release", 32'(barrier_release), 32'h05);
      sync_req = '0;
      cyc(1);
      exit_req = 4'b0101; cyc(1); exit_req = '0;
      chk("t2_done", 32'(kernel_done), 1);
      cyc(1);

      // Exit of the last straggler completes the barrier for the rest.
      launch(4'b1111);
      sync_req = 4'b0111;
      cyc(2);
      exit_req = 4'b1000; cyc(1); exit_req = '0;
      chk("t3_release", 32'(barrier_release), 32'h07);
      chk("t3_active", 32'(core_active), 32'h07);
      cyc(1);
      sync_req = '0;
      cyc(1);

      // SYNC and EXIT together on core 2 while the others exit: no release, just done.
      sync_req = 4'b0100; exit_req = 4'b0111;
      cyc(1);
      sync_req = '0; exit_req = '0;
      chk("t4_no_release", 32'(barrier_release), 0);
      chk("t4_done", 32'(kernel_done), 1);
      chk("t4_busy_still", 32'(busy), 1);
      cyc(1);
      chk("t4_done_pulse", 32'(kernel_done), 0);
      chk("t4_busy_fall", 32'(busy), 0);
      chk("t4_active", 32'(core_active), 0);

      // Watchdog: one core parked long enough to saturate the 4-bit counter.
      launch(4'b0011);
      sync_req = 4'b0001;
      cyc(1);
      cyc(14);
      chk("t5_not_yet", 32'(timeout_err), 0);
      cyc(2);
      chk("t5_timeout", 32'(timeout_err), 1);
      launch(4'b1111);
      chk("t5_start_ignored", 32'(core_active), 32'h03);
      cyc(3);
      chk("t5_sticky", 32'(timeout_err), 1);
      sync_req = '0; exit_req = 4'b0011; cyc(1); exit_req = '0;
      cyc(1);
      launch(4'b0001);
      chk("t5_cleared", 32'(timeout_err), 0);
      chk("t5_new_active", 32'(core_active), 32'h01);
      exit_req = 4'b0001; cyc(1); exit_req = '0;
      cyc(1);

      // Asynchronous reset with a half-gathered barrier.
      launch(4'b1111);
      sync_req = 4'b0011;
      cyc(2);
      #2 rst_n = 1'b0;
      #1;
      chk("t6_rst_active", 32'(core_active), 0);
      chk("t6_rst_busy", 32'(busy), 0);
      chk("t6_rst_all", 32'({barrier_release, barrier_count, kernel_done, timeout_err}), 0);
      sync_req = '0;
      cyc(2);
      rst_n = 1'b1;
      launch(4'b0000);
      chk("t6_zero_done", 32'(kernel_done), 1);
      cyc(1);
      chk("t6_zero_idle", 32'(busy), 0);
      cyc(2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/barrier_sync_ctrl.md
# barrier_sync_ctrl

Kernel-level sequencer for the SYNC and EXIT control instructions across NUM_CORES cores. It launches a kernel on a selected core mask and tracks which cores are still running. It holds cores that reach SYNC until every still-active core has arrived, then releases them together. It signals kernel completion once every core has executed EXIT. It sits between the per-core control units (which decode SYNC/EXIT) and the top-level host/launch logic.

## Interface
Parameters:
- NUM_CORES, 4, number of cores supervised (≥1)
- TIMEOUT_WIDTH, 16, width of barrier-wait watchdog counter

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  kernel launch pulse; honoured only in IDLE
- core_mask  in  NUM_CORES  cores enabled for the launched kernel; sampled with start
- sync_req  in  NUM_CORES  level; core i raises it on SYNC and holds it until it sees barrier_release[i]
- exit_req  in  NUM_CORES  one-cycle pulse; core i executed EXIT
- core_active  out  NUM_CORES  registered; core i is running the current kernel
- barrier_release  out  NUM_CORES  registered one-cycle pulse; releases waiting cores
- barrier_count  out  8  completed barriers since start; wraps 255→0
- busy  out  1  high in any state except IDLE
- kernel_done  out  1  one-cycle pulse when all cores have exited
- timeout_err  out  1  sticky; barrier wait reached counter max

## Operation
- Internal state: active[N], arrived[N], wait_cnt[TIMEOUT_WIDTH], FSM {IDLE, RUN, RELEASE, DONE}.
- IDLE: on start, active←core_mask, arrived←0, barrier_count←0, wait_cnt←0, timeout_err←0. Go to DONE if core_mask==0, otherwise go to RUN. start is ignored in every other state.
- RUN, per cycle:
  - exits = exit_req & active. Both active and arrived clear those bits.
  - arr_next = (arrived | (sync_req & active)) & ~exits. EXIT beats SYNC when both occur on the same core in the same cycle.
  - act_next = active & ~exits.
  - If act_next==0, go to DONE. Exit beats barrier completion.
  - Else if arr_next==act_next, go to RELEASE. This also covers the case where an exit completes a barrier that the remaining cores were already waiting on.
  - Else stay in RUN.
  - sync_req from inactive cores is ignored. Exit pulses from inactive cores are ignored.
- RELEASE (1 cycle):
  - barrier_release = the arrived set latched on entry.
  - arrived←0, wait_cnt←0, barrier_count increments (mod 256).
  - sync_req is ignored. exit_req is still honoured, and the bit is removed from active.
  - Return to RUN, or go to DONE if active became 0.
- DONE (1 cycle): kernel_done=1, active←0, then go to IDLE.
- Watchdog:
  - In RUN with arrived≠0, wait_cnt increments and saturates at 2^TIMEOUT_WIDTH−1.
  - On reaching the max, timeout_err←1. It is sticky until the next accepted start.
  - Cores are not released by a timeout.
- Reset (asynchronous, any time, including mid-barrier):
  - FSM←IDLE.
  - All outputs and internal registers ←0: core_active, barrier_release, barrier_count, busy, kernel_done, timeout_err.

## Timing
- All outputs are registered and reflect state after the clock edge.
- Start at edge t: busy and core_active valid from t+1.
- Last arrival sampled at edge t: barrier_release is high for exactly the cycle after t (state RELEASE). The core drops sync_req from the following cycle.
  - Minimum barrier-completion latency is 1 cycle after the last sync_req is seen.
  - Back-to-back barriers are possible, with one RUN cycle minimum between releases.
- Last exit sampled at edge t: kernel_done high for the cycle after t; busy falls one cycle later.
- A core whose sync_req stays high after its release is counted as arriving at the next barrier. Cores must honour the drop rule.

## Test plan
- Launch core_mask=4'b1111. Cores raise sync_req at cycles 2, 5, 5, 9 → barrier_release=4'b1111 for exactly 1 cycle after the cycle-9 sample, and barrier_count=1.
- core_mask=4'b0101. sync_req on cores 1 and 3 (inactive) only → no release and no timeout increment. Then cores 0 and 2 sync → release=4'b0101.
- Cores 0, 1, 2 waiting while core 3 pulses exit_req → release=4'b0111 next cycle, and core_active=4'b0111.
- Core 2 asserts sync_req and exit_req in the same cycle while the others exit → no release. kernel_done pulses once, busy falls the following cycle, and core_active=0.
- TIMEOUT_WIDTH=4. One core waits 15+ cycles → timeout_err=1 and stays set. A new start clears it. start while busy is ignored, with core_active unchanged.
- Assert rst_n=0 asynchronously mid-barrier (arrived=4'b0011) → all outputs are 0 immediately. After release of reset, state is IDLE and a new start with core_mask=0 gives kernel_done one cycle later.
